// File: rtl/data_sram_responder.sv
// Data-side SRAM-like responder: byte-masked word memory with an in-order,
// fixed-latency response queue holding up to DEPTH outstanding transactions.
module data_sram_responder #(
  parameter int unsigned ADDR_W  = 12,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned LATENCY = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     data_sram_req,
  input  logic                     data_sram_wr,
  input  logic [1:0]               data_sram_size,
  input  logic [3:0]               data_sram_wstrb,
  input  logic [31:0]              data_sram_addr,
  input  logic [31:0]              data_sram_wdata,
  output logic                     data_sram_addr_ok,
  output logic                     data_sram_data_ok,
  output logic [31:0]              data_sram_rdata,
  output logic [$clog2(DEPTH):0]   outstanding
);

  localparam int unsigned PTR_W    = $clog2(DEPTH);
  localparam int unsigned CNT_W    = PTR_W + 1;
  localparam int unsigned WORDS    = 1 << ADDR_W;
  // Stored wait is LATENCY-2: the accept edge and the pop edge each account for one cycle.
  localparam int unsigned TMR_W    = (LATENCY > 2) ? $clog2(LATENCY) : 1;
  localparam int unsigned TMR_INIT = (LATENCY >= 2) ? LATENCY - 2 : 0;

  logic [31:0]       mem    [WORDS];
  logic [31:0]       q_data [DEPTH];
  logic [TMR_W-1:0]  q_tmr  [DEPTH];
  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;
  logic [ADDR_W-1:0] idx;
  logic [31:0]       acc_data;
  logic              accept;
  logic              push;
  logic              pop;
  logic              bypass;
  logic              unused_bits;

  assign idx               = data_sram_addr[ADDR_W+1:2];
  assign data_sram_addr_ok = (outstanding < CNT_W'(DEPTH)) & ~reset;
  assign accept            = data_sram_req & data_sram_addr_ok;
  assign acc_data          = data_sram_wr ? 32'h0 : mem[idx];
  // Single-cycle latency with an empty queue answers on the accept edge itself.
  assign bypass            = (LATENCY == 1) && accept && (outstanding == '0);
  assign push              = accept & ~bypass;
  assign pop               = (outstanding != '0) && (q_tmr[head] == '0);
  assign unused_bits       = ^{data_sram_size, data_sram_addr[31:ADDR_W+2], data_sram_addr[1:0]};

  // Word array; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (accept && data_sram_wr) begin
      for (int i = 0; i < 4; i++) begin
        if (data_sram_wstrb[i]) begin
          mem[idx][8*i +: 8] <= data_sram_wdata[8*i +: 8];
        end
      end
    end
  end

  // Response queue, timers and registered response outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      head              <= '0;
      tail              <= '0;
      outstanding       <= '0;
      data_sram_data_ok <= 1'b0;
      data_sram_rdata   <= 32'h0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (q_tmr[i] != '0) begin
          q_tmr[i] <= q_tmr[i] - TMR_W'(1);
        end
      end
      if (push) begin
        q_data[tail] <= acc_data;
        q_tmr[tail]  <= TMR_W'(TMR_INIT);
        tail         <= tail + PTR_W'(1);
      end
      if (pop) begin
        head              <= head + PTR_W'(1);
        data_sram_data_ok <= 1'b1;
        data_sram_rdata   <= q_data[head];
      end else if (bypass) begin
        data_sram_data_ok <= 1'b1;
        data_sram_rdata   <= acc_data;
      end else begin
        data_sram_data_ok <= 1'b0;
      end
      outstanding <= outstanding + CNT_W'(push) - CNT_W'(pop);
    end
  end

endmodule

// File: tb/tb_data_sram_responder.sv
// Bench for data_sram_responder: two instances (LATENCY 2 and 6) checked every
// cycle against a due-time response queue and a word-array memory model.
module tb_data_sram_responder;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        req   [2];
  logic        wr    [2];
  logic [1:0]  size  [2];
  logic [3:0]  wstrb [2];
  logic [31:0] addr  [2];
  logic [31:0] wdata [2];
  logic        aok   [2];
  logic        dok   [2];
  logic [31:0] rdata [2];
  logic [2:0]  outs  [2];

  always #5 clk = ~clk;

  data_sram_responder #(.ADDR_W(12), .DEPTH(4), .LATENCY(2)) u_dut (
    .clk(clk), .reset(reset), .data_sram_req(req[0]), .data_sram_wr(wr[0]),
    .data_sram_size(size[0]), .data_sram_wstrb(wstrb[0]), .data_sram_addr(addr[0]),
    .data_sram_wdata(wdata[0]), .data_sram_addr_ok(aok[0]), .data_sram_data_ok(dok[0]),
    .data_sram_rdata(rdata[0]), .outstanding(outs[0]));

  data_sram_responder #(.ADDR_W(12), .DEPTH(4), .LATENCY(6)) u_full (
    .clk(clk), .reset(reset), .data_sram_req(req[1]), .data_sram_wr(wr[1]),
    .data_sram_size(size[1]), .data_sram_wstrb(wstrb[1]), .data_sram_addr(addr[1]),
    .data_sram_wdata(wdata[1]), .data_sram_addr_ok(aok[1]), .data_sram_data_ok(dok[1]),
    .data_sram_rdata(rdata[1]), .outstanding(outs[1]));

  typedef struct {
    int          dut;
    int          due;
    logic [31:0] data;
  } resp_t;

  resp_t       q[$];
  logic [31:0] mm [2][4096];
  int          m_out [2];
  int          last_due [2];
  logic [31:0] m_rdata [2];
  logic [36:0] o_vec [2];
  logic [36:0] e_vec [2];
  logic        o_dok [2];
  logic        o_aok [2];
  logic [31:0] o_rdata [2];
  logic [2:0]  o_out [2];
  int          cyc = 0;
  int          obs_cyc = 0;
  int          total = 0;
  int          bad = 0;

  function automatic int lat_of(int d);
    return (d == 0) ? 2 : 6;
  endfunction

  task automatic drive(int d, logic r, logic w, logic [3:0] s, logic [31:0] a, logic [31:0] wd);
    req[d] = r; wr[d] = w; wstrb[d] = s; addr[d] = a; wdata[d] = wd; size[d] = 2'd2;
  endtask

  task automatic idle();
    for (int d = 0; d < 2; d++) drive(d, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
  endtask

  // One clock: sample outputs mid-cycle, compute the expected outputs, then apply this cycle's inputs to the model.
  task automatic tick();
    int          fi;
    resp_t       r;
    logic [11:0] idx;
    logic        e_dok;
    logic        e_aok;
    int          due;
    @(negedge clk);
    obs_cyc = cyc;
    for (int d = 0; d < 2; d++) begin
      fi = -1;
      for (int i = 0; i < q.size(); i++) if (q[i].dut == d && fi < 0) fi = i;
      e_dok = 1'b0;
      if (fi >= 0 && q[fi].due == cyc) begin
        e_dok = 1'b1; m_rdata[d] = q[fi].data; q.delete(fi); m_out[d]--;
      end
      e_aok = !reset && (m_out[d] < DEPTH);
      e_vec[d] = {e_dok, m_rdata[d], e_aok, 3'(m_out[d])};
      o_dok[d] = dok[d]; o_aok[d] = aok[d]; o_rdata[d] = rdata[d]; o_out[d] = outs[d];
      o_vec[d] = {dok[d], rdata[d], aok[d], outs[d]};
      if (req[d] && e_aok) begin
        idx = addr[d][13:2];
        due = cyc + lat_of(d);
        if (due <= last_due[d]) due = last_due[d] + 1;
        r.dut = d; r.due = due;
        if (wr[d]) begin
          for (int b = 0; b < 4; b++) if (wstrb[d][b]) mm[d][idx][8*b +: 8] = wdata[d][8*b +: 8];
          r.data = 32'h0;
        end else begin
          r.data = mm[d][idx];
        end
        q.push_back(r); last_due[d] = due; m_out[d]++;
      end
    end
    if (reset) begin
      q.delete(); m_out = '{0, 0}; m_rdata = '{32'h0, 32'h0};
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; idle();
    repeat (3) tick();
    reset = 1'b0;
    tick();
    for (int d = 0; d < 2; d++) begin
      total++;
      if (o_vec[d] !== {1'b0, 32'h0, 1'b1, 3'd0}) begin
        bad++; $display("FAIL reset_state dut=%0d got=%h exp=%h", d, o_vec[d], {1'b0, 32'h0, 1'b1, 3'd0});
      end
    end
  endtask

  task automatic test_write_read();
    int t0, lat;
    logic [31:0] got;
    for (int pass = 0; pass < 2; pass++) begin
      if (pass == 0) drive(0, 1'b1, 1'b1, 4'hF, 32'h10, 32'hDEADBEEF);
      else           drive(0, 1'b1, 1'b0, 4'h0, 32'h10, 32'h0);
      lat = -1; got = 32'h0;
      tick(); t0 = obs_cyc; idle();
      for (int k = 0; k < 8; k++) begin
        tick();
        for (int d = 0; d < 2; d++) begin
          total++;
          if (o_vec[d] !== e_vec[d]) begin
            bad++; $display("FAIL wr_rd_model dut=%0d cyc=%0d got=%h exp=%h", d, obs_cyc, o_vec[d], e_vec[d]);
          end
        end
        if (o_dok[0] && lat < 0) begin lat = obs_cyc - t0; got = o_rdata[0]; end
      end
      total++;
      if (lat !== 2) begin bad++; $display("FAIL latency pass=%0d got=%0d exp=2", pass, lat); end
      if (pass == 1) begin
        total++;
        if (got !== 32'hDEADBEEF) begin bad++; $display("FAIL read_data got=%h exp=deadbeef", got); end
      end
    end
  endtask

  task automatic test_byte_write();
    logic [31:0] got = 32'h0;
    drive(0, 1'b1, 1'b1, 4'hF, 32'h10, 32'h11223344); tick();
    drive(0, 1'b1, 1'b1, 4'h8, 32'h13, 32'h5A5A5A5A); tick();
    drive(0, 1'b1, 1'b0, 4'h0, 32'h10, 32'h0);        tick();
    idle();
    for (int k = 0; k < 6; k++) begin
      tick();
      total++;
      if (o_vec[0] !== e_vec[0]) begin
        bad++; $display("FAIL byte_model cyc=%0d got=%h exp=%h", obs_cyc, o_vec[0], e_vec[0]);
      end
      if (o_dok[0]) got = o_rdata[0];
    end
    total++;
    if (got !== 32'h5A223344) begin bad++; $display("FAIL byte_merge got=%h exp=5a223344", got); end
  endtask

  task automatic test_back_to_back();
    int c_wr = -1, c_rd = -1;
    logic [31:0] d_wr = 32'hX, d_rd = 32'hX;
    drive(0, 1'b1, 1'b1, 4'hF, 32'h20, 32'hCAFEF00D); tick();
    drive(0, 1'b1, 1'b0, 4'h0, 32'h20, 32'h0);
    for (int k = 0; k < 8; k++) begin
      tick(); idle();
      if (o_dok[0]) begin
        if (c_wr < 0) begin c_wr = obs_cyc; d_wr = o_rdata[0]; end
        else if (c_rd < 0) begin c_rd = obs_cyc; d_rd = o_rdata[0]; end
      end
    end
    total++;
    if ({d_wr, d_rd} !== {32'h0, 32'hCAFEF00D}) begin
      bad++; $display("FAIL raw_data got=%h/%h exp=0/cafef00d", d_wr, d_rd);
    end
    total++;
    if (c_rd - c_wr !== 1) begin bad++; $display("FAIL raw_spacing got=%0d exp=1", c_rd - c_wr); end
  endtask

  task automatic test_full();
    int n_acc = 0, n_dok = 0, first_dok = -1, aok_back = -1;
    bit saw_full = 1'b0;
    for (int k = 0; k < 30; k++) begin
      if (k < 16) drive(1, 1'b1, 1'b1, 4'hF, 32'h100 + 32'(k * 4), 32'(k));
      else        drive(1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      tick();
      total++;
      if (o_vec[1] !== e_vec[1]) begin
        bad++; $display("FAIL full_model cyc=%0d got=%h exp=%h", obs_cyc, o_vec[1], e_vec[1]);
      end
      if (req[1] && o_aok[1]) n_acc++;
      if (o_dok[1]) begin n_dok++; if (first_dok < 0) first_dok = obs_cyc; end
      if (!o_aok[1] && o_out[1] == 3'd4) saw_full = 1'b1;
      if (saw_full && o_aok[1] && aok_back < 0) aok_back = obs_cyc;
    end
    idle();
    total++;
    if (!saw_full) begin bad++; $display("FAIL full_reached got=0 exp=1"); end
    total++;
    if (n_acc !== n_dok || n_acc < 4) begin
      bad++; $display("FAIL accept_vs_dok got acc=%0d dok=%0d exp equal and >=4", n_acc, n_dok);
    end
    total++;
    if (aok_back !== first_dok) begin
      bad++; $display("FAIL aok_return got=%0d exp=%0d", aok_back, first_dok);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] got = 32'h0;
    for (int k = 0; k < 3; k++) begin
      drive(1, 1'b1, 1'b1, 4'hF, 32'h200 + 32'(k * 4), 32'hA0000000 + 32'(k)); tick();
    end
    idle();
    reset = 1'b1; tick(); reset = 1'b0;
    total++;
    if (o_out[1] !== 3'd3) begin bad++; $display("FAIL pre_reset_out got=%0d exp=3", o_out[1]); end
    for (int k = 0; k < 10; k++) begin
      tick();
      total++;
      if ({o_dok[1], o_out[1], o_aok[1]} !== {1'b0, 3'd0, 1'b1} || o_vec[1] !== e_vec[1]) begin
        bad++; $display("FAIL post_reset cyc=%0d got=%h exp=%h", obs_cyc, o_vec[1], e_vec[1]);
      end
    end
    drive(1, 1'b1, 1'b0, 4'h0, 32'h204, 32'h0); tick(); idle();
    for (int k = 0; k < 9; k++) begin
      tick();
      if (o_dok[1]) got = o_rdata[1];
    end
    total++;
    if (got !== 32'hA0000001) begin bad++; $display("FAIL mem_kept got=%h exp=a0000001", got); end
  endtask

  task automatic test_wrap();
    logic [31:0] seen[$];
    for (int i = 0; i < 20; i++) begin drive(0, 1'b1, 1'b1, 4'hF, 32'(i * 4), 32'(i)); tick(); end
    idle();
    repeat (6) tick();
    for (int i = 0; i < 28; i++) begin
      if (i < 20) drive(0, 1'b1, 1'b0, 4'h0, 32'(i * 4), 32'h0);
      else        idle();
      tick();
      total++;
      if (o_vec[0] !== e_vec[0]) begin
        bad++; $display("FAIL wrap_model cyc=%0d got=%h exp=%h", obs_cyc, o_vec[0], e_vec[0]);
      end
      if (o_dok[0]) seen.push_back(o_rdata[0]);
    end
    total++;
    if (seen.size() != 20) begin bad++; $display("FAIL wrap_count got=%0d exp=20", seen.size()); end
    for (int i = 0; i < seen.size() && i < 20; i++) begin
      total++;
      if (seen[i] !== 32'(i)) begin bad++; $display("FAIL wrap_order idx=%0d got=%h exp=%h", i, seen[i], 32'(i)); end
    end
  endtask

  task automatic test_random();
    logic [31:0] a;
    for (int k = 0; k < 320; k++) begin
      if (k < 300) begin
        a = ($urandom() & 32'hFFFFC003) | (32'($urandom_range(0, 19)) << 2);
        drive(0, 1'($urandom()), 1'($urandom()), 4'($urandom()), a, $urandom());
        size[0] = 2'($urandom());
      end else begin
        idle();
      end
      tick();
      for (int d = 0; d < 2; d++) begin
        total++;
        if (o_vec[d] !== e_vec[d]) begin
          bad++; $display("FAIL random_model dut=%0d cyc=%0d got=%h exp=%h", d, obs_cyc, o_vec[d], e_vec[d]);
        end
      end
    end
  endtask

  initial begin
    m_rdata  = '{32'h0, 32'h0};
    last_due = '{-100, -100};
    m_out    = '{0, 0};
    test_reset();
    test_write_read();
    test_byte_write();
    test_back_to_back();
    test_full();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog cyc=%0d exp=finish", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
